// File: rtl/int_seq_if.sv
// Interrupt sequencer bus bundle: control-unit handshake inputs and the
// stack/vector control outputs produced by the sequencer.
interface int_seq_if;
    // Inputs to the sequencer
    logic        NMI;
    logic        IRQ;
    logic        READY;
    logic        SYNC;
    logic        i_iflag;
    logic        i_brk;

    // Outputs from the sequencer
    logic        o_busy;
    logic        o_rw;
    logic [1:0]  o_push;
    logic        o_sdec;
    logic [15:0] o_vec_addr;
    logic [1:0]  o_vec_fetch;
    logic        o_b_flag;
    logic        o_set_i;
    logic        o_done;

    // Sequencer side
    modport master (
        input  NMI,
        input  IRQ,
        input  READY,
        input  SYNC,
        input  i_iflag,
        input  i_brk,
        output o_busy,
        output o_rw,
        output o_push,
        output o_sdec,
        output o_vec_addr,
        output o_vec_fetch,
        output o_b_flag,
        output o_set_i,
        output o_done
    );

    // Control unit / environment side
    modport slave (
        output NMI,
        output IRQ,
        output READY,
        output SYNC,
        output i_iflag,
        output i_brk,
        input  o_busy,
        input  o_rw,
        input  o_push,
        input  o_sdec,
        input  o_vec_addr,
        input  o_vec_fetch,
        input  o_b_flag,
        input  o_set_i,
        input  o_done
    );
endinterface

// File: rtl/int_seq.sv
// Interrupt / reset / BRK entry sequencer. Runs the seven-cycle 6502-style
// entry sequence: dummy read, push PCH, PCL, P, then fetch the vector.
module int_seq #(
    parameter logic [15:0] NMI_VEC = 16'hFFFA,
    parameter logic [15:0] RST_VEC = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    int_seq_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StS1,
        StS2,
        StS3,
        StS4,
        StS5,
        StS6
    } state_e;

    typedef enum logic [1:0] {
        SrcRst,
        SrcNmi,
        SrcBrk,
        SrcIrq
    } src_e;

    state_e      state_q;
    src_e        src_q;
    logic        rst_pend_q;
    logic        nmi_pend_q;
    logic        nmi_q;
    logic [15:0] vec_q;

    logic        irq_act;
    logic        nmi_edge;
    logic        is_rst;
    logic        waits_ready;
    logic        advance;
    logic        nmi_hit;
    logic [15:0] vec_sel;
    logic        start_req;
    src_e        start_src;

    logic        busy;
    logic        rw;
    logic [1:0]  push;
    logic        sdec;
    logic [15:0] vec_addr;
    logic [1:0]  vec_fetch;
    logic        b_flag;
    logic        set_i;
    logic        done;

    // Request detection, stall rule and vector resolution
    always_comb begin
        irq_act  = ~bus.IRQ & ~bus.i_iflag;
        nmi_edge = nmi_q & ~bus.NMI;
        is_rst   = (src_q == SrcRst);

        // A reset sequence is all reads, so every state waits on READY
        waits_ready = (state_q == StS1) || (state_q == StS5) || (state_q == StS6) || is_rst;
        advance     = (state_q != StIdle) && (bus.READY || !waits_ready);

        // A pending NMI takes over a BRK or IRQ sequence still pushing state
        nmi_hit = (src_q == SrcNmi) ||
                  (nmi_pend_q && ((src_q == SrcBrk) || (src_q == SrcIrq)));
        if (nmi_hit) begin
            vec_sel = NMI_VEC;
        end else if (is_rst) begin
            vec_sel = RST_VEC;
        end else begin
            vec_sel = IRQ_VEC;
        end

        // Entry priority: RST > NMI > BRK > IRQ
        start_req = 1'b1;
        start_src = SrcRst;
        if (rst_pend_q) begin
            start_src = SrcRst;
        end else if (bus.SYNC && nmi_pend_q) begin
            start_src = SrcNmi;
        end else if (bus.i_brk) begin
            start_src = SrcBrk;
        end else if (bus.SYNC && irq_act) begin
            start_src = SrcIrq;
        end else begin
            start_req = 1'b0;
        end
    end

    // Sequencer state, latched source, pending flags and resolved vector
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            src_q      <= SrcRst;
            rst_pend_q <= 1'b1;
            nmi_pend_q <= 1'b0;
            nmi_q      <= 1'b1;
            vec_q      <= 16'h0000;
        end else begin
            nmi_q <= bus.NMI;

            // A new edge wins over the clear in the vector-resolve cycle
            if (nmi_edge) begin
                nmi_pend_q <= 1'b1;
            end else if ((state_q == StS4) && advance && nmi_hit) begin
                nmi_pend_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (start_req) begin
                        state_q <= StS1;
                        src_q   <= start_src;
                    end
                end
                StS1: begin
                    if (advance) begin
                        state_q <= StS2;
                    end
                end
                StS2: begin
                    if (advance) begin
                        state_q <= StS3;
                    end
                end
                StS3: begin
                    if (advance) begin
                        state_q <= StS4;
                    end
                end
                StS4: begin
                    if (advance) begin
                        state_q <= StS5;
                        vec_q   <= vec_sel;
                    end
                end
                StS5: begin
                    if (advance) begin
                        state_q <= StS6;
                    end
                end
                StS6: begin
                    if (advance) begin
                        state_q <= StIdle;
                        if (is_rst) begin
                            rst_pend_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Output decode from registered state and latched source
    always_comb begin
        busy      = 1'b0;
        rw        = 1'b1;
        push      = 2'd0;
        sdec      = 1'b0;
        vec_addr  = 16'h0000;
        vec_fetch = 2'd0;
        b_flag    = 1'b0;
        set_i     = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
            end
            StS1: begin
                busy = 1'b1;
            end
            StS2: begin
                busy = 1'b1;
                sdec = 1'b1;
                if (!is_rst) begin
                    rw   = 1'b0;
                    push = 2'd1;
                end
            end
            StS3: begin
                busy = 1'b1;
                sdec = 1'b1;
                if (!is_rst) begin
                    rw   = 1'b0;
                    push = 2'd2;
                end
            end
            StS4: begin
                busy   = 1'b1;
                sdec   = 1'b1;
                b_flag = (src_q == SrcBrk) && !nmi_pend_q;
                if (!is_rst) begin
                    rw   = 1'b0;
                    push = 2'd3;
                end
            end
            StS5: begin
                busy      = 1'b1;
                vec_addr  = vec_q;
                vec_fetch = 2'd1;
            end
            StS6: begin
                busy      = 1'b1;
                vec_addr  = vec_q + 16'd1;
                vec_fetch = 2'd2;
                set_i     = bus.READY;
                done      = bus.READY;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign bus.o_busy      = busy;
    assign bus.o_rw        = rw;
    assign bus.o_push      = push;
    assign bus.o_sdec      = sdec;
    assign bus.o_vec_addr  = vec_addr;
    assign bus.o_vec_fetch = vec_fetch;
    assign bus.o_b_flag    = b_flag;
    assign bus.o_set_i     = set_i;
    assign bus.o_done      = done;

endmodule

// File: tb/tb_int_seq.sv
// Self-checking bench for int_seq: hand-written vector table, directed
// corner sequences, and random stimulus against a behavioural model.
module tb_int_seq;

    logic clk = 1'b0;
    logic rst_n;

    int_seq_if bus();

    int_seq #(
        .NMI_VEC(16'hFFFA),
        .RST_VEC(16'hFFFC),
        .IRQ_VEC(16'hFFFE)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Output word: {busy, rw, push, sdec, fetch, addr, b, set_i, done}
    function automatic logic [25:0] pack(input logic busy, input logic rw, input logic [1:0] push,
                                         input logic sdec, input logic [1:0] fetch,
                                         input logic [15:0] addr, input logic b,
                                         input logic seti, input logic done);
        return {busy, rw, push, sdec, fetch, addr, b, seti, done};
    endfunction

    function automatic logic [25:0] act_out();
        return pack(bus.o_busy, bus.o_rw, bus.o_push, bus.o_sdec, bus.o_vec_fetch,
                    bus.o_vec_addr, bus.o_b_flag, bus.o_set_i, bus.o_done);
    endfunction

    // ---------------- behavioural model ----------------
    localparam int SRST = 0;
    localparam int SNMI = 1;
    localparam int SBRK = 2;
    localparam int SIRQ = 3;

    int          m_pos = 0;   // 0 = idle, 1..6 = step of the entry sequence
    int          m_src = SRST;
    bit          m_rst_pend = 1'b1;
    bit          m_nmi_pend = 1'b0;
    bit          m_nmi_prev = 1'b1;
    logic [15:0] m_vec = 16'h0000;

    function automatic logic [25:0] model_out();
        bit          wr;
        logic [1:0]  push;
        logic [1:0]  fetch;
        logic [15:0] addr;
        wr    = (m_pos >= 2) && (m_pos <= 4) && (m_src != SRST);
        push  = wr ? 2'(m_pos - 1) : 2'd0;
        fetch = (m_pos == 5) ? 2'd1 : (m_pos == 6) ? 2'd2 : 2'd0;
        addr  = (m_pos == 5) ? m_vec : (m_pos == 6) ? m_vec + 16'd1 : 16'h0000;
        return pack(m_pos != 0, !wr, push, (m_pos >= 2) && (m_pos <= 4), fetch, addr,
                    (m_pos == 4) && (m_src == SBRK) && !m_nmi_pend,
                    (m_pos == 6) && bus.READY, (m_pos == 6) && bus.READY);
    endfunction

    task automatic model_step();
        bit edge_seen;
        bit clr;
        bit stall;
        bit to_nmi;
        if (!rst_n) begin
            m_pos = 0; m_src = SRST; m_rst_pend = 1; m_nmi_pend = 0; m_nmi_prev = 1;
            m_vec = 16'h0000;
            return;
        end
        edge_seen  = m_nmi_prev && !bus.NMI;
        m_nmi_prev = bus.NMI;
        clr = 0;
        if (m_pos == 0) begin
            if (m_rst_pend) begin
                m_src = SRST; m_pos = 1;
            end else if (bus.SYNC && m_nmi_pend) begin
                m_src = SNMI; m_pos = 1;
            end else if (bus.i_brk) begin
                m_src = SBRK; m_pos = 1;
            end else if (bus.SYNC && !bus.IRQ && !bus.i_iflag) begin
                m_src = SIRQ; m_pos = 1;
            end
        end else begin
            stall = !bus.READY && (m_pos == 1 || m_pos == 5 || m_pos == 6 || m_src == SRST);
            if (!stall) begin
                if (m_pos == 4) begin
                    to_nmi = (m_src == SNMI) ||
                             (m_nmi_pend && (m_src == SBRK || m_src == SIRQ));
                    m_vec  = to_nmi ? 16'hFFFA : (m_src == SRST) ? 16'hFFFC : 16'hFFFE;
                    clr    = to_nmi;
                end
                if (m_pos == 6) begin
                    if (m_src == SRST) m_rst_pend = 0;
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
        end
        if (edge_seen) m_nmi_pend = 1;
        else if (clr) m_nmi_pend = 0;
    endtask

    task automatic sample();
        @(negedge clk);
        check("model_cycle", 32'(act_out()), 32'(model_out()));
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst_n;
        logic        irq;
        logic        sync;
        logic        iflag;
        logic        brk;
        logic [25:0] exp;
    } vec_t;

    vec_t vtab[$];

    function automatic vec_t mk(input logic r, input logic irq, input logic sync,
                                input logic iflag, input logic brk, input logic [25:0] exp);
        vec_t v;
        v.rst_n = r; v.irq = irq; v.sync = sync; v.iflag = iflag; v.brk = brk; v.exp = exp;
        return v;
    endfunction

    int done_cnt;
    int busy_cnt;
    int wr_cnt;

    initial begin
        logic [25:0] idle_o;
        idle_o = pack(0, 1, 2'd0, 0, 2'd0, 16'h0000, 0, 0, 0);

        // Reset release: read-only sequence to FFFC
        vtab.push_back(mk(0, 1, 0, 1, 0, idle_o));
        vtab.push_back(mk(1, 1, 0, 1, 0, idle_o));
        vtab.push_back(mk(1, 1, 0, 1, 0, pack(1, 1, 2'd0, 0, 2'd0, 16'h0000, 0, 0, 0)));
        vtab.push_back(mk(1, 1, 0, 1, 0, pack(1, 1, 2'd0, 1, 2'd0, 16'h0000, 0, 0, 0)));
        vtab.push_back(mk(1, 1, 0, 1, 0, pack(1, 1, 2'd0, 1, 2'd0, 16'h0000, 0, 0, 0)));
        vtab.push_back(mk(1, 1, 0, 1, 0, pack(1, 1, 2'd0, 1, 2'd0, 16'h0000, 0, 0, 0)));
        vtab.push_back(mk(1, 1, 0, 1, 0, pack(1, 1, 2'd0, 0, 2'd1, 16'hFFFC, 0, 0, 0)));
        vtab.push_back(mk(1, 1, 0, 1, 0, pack(1, 1, 2'd0, 0, 2'd2, 16'hFFFD, 0, 1, 1)));
        vtab.push_back(mk(1, 1, 0, 1, 0, idle_o));
        // IRQ with I clear
        vtab.push_back(mk(1, 0, 1, 0, 0, idle_o));
        vtab.push_back(mk(1, 0, 0, 0, 0, pack(1, 1, 2'd0, 0, 2'd0, 16'h0000, 0, 0, 0)));
        vtab.push_back(mk(1, 0, 0, 0, 0, pack(1, 0, 2'd1, 1, 2'd0, 16'h0000, 0, 0, 0)));
        vtab.push_back(mk(1, 0, 0, 0, 0, pack(1, 0, 2'd2, 1, 2'd0, 16'h0000, 0, 0, 0)));
        vtab.push_back(mk(1, 0, 0, 0, 0, pack(1, 0, 2'd3, 1, 2'd0, 16'h0000, 0, 0, 0)));
        vtab.push_back(mk(1, 0, 0, 0, 0, pack(1, 1, 2'd0, 0, 2'd1, 16'hFFFE, 0, 0, 0)));
        vtab.push_back(mk(1, 0, 0, 0, 0, pack(1, 1, 2'd0, 0, 2'd2, 16'hFFFF, 0, 1, 1)));
        // IRQ with I set: masked
        vtab.push_back(mk(1, 0, 1, 1, 0, idle_o));
        vtab.push_back(mk(1, 0, 1, 1, 0, idle_o));
        vtab.push_back(mk(1, 1, 0, 1, 0, idle_o));
        // BRK: B set in the pushed P
        vtab.push_back(mk(1, 1, 0, 1, 1, idle_o));
        vtab.push_back(mk(1, 1, 0, 1, 0, pack(1, 1, 2'd0, 0, 2'd0, 16'h0000, 0, 0, 0)));
        vtab.push_back(mk(1, 1, 0, 1, 0, pack(1, 0, 2'd1, 1, 2'd0, 16'h0000, 0, 0, 0)));
        vtab.push_back(mk(1, 1, 0, 1, 0, pack(1, 0, 2'd2, 1, 2'd0, 16'h0000, 0, 0, 0)));
        vtab.push_back(mk(1, 1, 0, 1, 0, pack(1, 0, 2'd3, 1, 2'd0, 16'h0000, 1, 0, 0)));
        vtab.push_back(mk(1, 1, 0, 1, 0, pack(1, 1, 2'd0, 0, 2'd1, 16'hFFFE, 0, 0, 0)));
        vtab.push_back(mk(1, 1, 0, 1, 0, pack(1, 1, 2'd0, 0, 2'd2, 16'hFFFF, 0, 1, 1)));
        vtab.push_back(mk(1, 1, 0, 1, 0, idle_o));

        rst_n = 1'b0;
        bus.NMI = 1'b1; bus.IRQ = 1'b1; bus.READY = 1'b1;
        bus.SYNC = 1'b0; bus.i_iflag = 1'b1; bus.i_brk = 1'b0;

        foreach (vtab[i]) begin
            rst_n = vtab[i].rst_n; bus.IRQ = vtab[i].irq; bus.SYNC = vtab[i].sync;
            bus.i_iflag = vtab[i].iflag; bus.i_brk = vtab[i].brk;
            sample();
            check($sformatf("table_row_%0d", i), 32'(act_out()), 32'(vtab[i].exp));
            advance();
        end

        // BRK hijacked by an NMI edge during S3
        bus.IRQ = 1; bus.SYNC = 0; bus.i_iflag = 1; bus.i_brk = 1;
        sample(); advance();
        bus.i_brk = 0;
        sample(); advance();               // S1
        sample(); advance();               // S2
        bus.NMI = 0;
        sample(); advance();               // S3, NMI falls
        sample();                          // S4
        check("hijack_b_flag", 32'(bus.o_b_flag), 32'd0);
        check("hijack_push_p", 32'(bus.o_push), 32'd3);
        advance();
        sample();
        check("hijack_vec_lo", 32'(bus.o_vec_addr), 32'hFFFA);
        advance();
        sample();
        check("hijack_vec_hi", 32'(bus.o_vec_addr), 32'hFFFB);
        check("hijack_done", 32'(bus.o_done), 32'd1);
        advance();
        for (int i = 0; i < 6; i++) begin
            bus.SYNC = i[0];
            sample();
            check("nmi_no_retrigger", 32'(bus.o_busy), 32'd0);
            advance();
        end
        bus.SYNC = 0;

        // NMI held low for 20 cycles across two SYNC pulses
        bus.NMI = 1;
        sample(); advance();
        sample(); advance();
        done_cnt = 0;
        bus.NMI = 0;
        for (int i = 0; i < 20; i++) begin
            bus.SYNC = (i == 2) || (i == 12);
            sample();
            if (bus.o_done) done_cnt++;
            advance();
        end
        check("nmi_held_one_seq", 32'(done_cnt), 32'd1);
        bus.SYNC = 0; bus.NMI = 1;
        sample(); advance();

        // IRQ with READY low in S3 (ignored) and two cycles in S5 (stall)
        bus.IRQ = 0; bus.i_iflag = 0; bus.SYNC = 1;
        sample(); advance();
        bus.IRQ = 1; bus.SYNC = 0;
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            bus.READY = !((i == 2) || (i == 4) || (i == 5));
            sample();
            if (bus.o_busy) busy_cnt++;
            if (i == 3) check("s3_advances_unready", 32'(bus.o_push), 32'd3);
            if (i == 6) check("s5_held_vec", 32'(bus.o_vec_fetch), 32'd1);
            advance();
        end
        bus.READY = 1;
        check("stall_length", 32'(busy_cnt), 32'd8);

        // Reset asserted during S4 of an IRQ sequence
        bus.IRQ = 0; bus.i_iflag = 0; bus.SYNC = 1;
        sample(); advance();
        bus.IRQ = 1; bus.SYNC = 0;
        wr_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            rst_n = (i != 3);
            sample();
            if (i >= 4 && !bus.o_rw) wr_cnt++;
            if (i == 9) check("rst_abort_vec_lo", 32'(bus.o_vec_addr), 32'hFFFC);
            if (i == 10) check("rst_abort_done", 32'(bus.o_done), 32'd1);
            advance();
        end
        check("rst_abort_no_writes", 32'(wr_cnt), 32'd0);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom % 64) != 0;
            if (($urandom % 8) == 0) bus.NMI = ~bus.NMI;
            bus.IRQ     = ($urandom % 3) != 0;
            bus.i_iflag = ($urandom % 2) != 0;
            bus.READY   = ($urandom % 4) != 0;
            bus.SYNC    = ($urandom % 4) == 0;
            bus.i_brk   = ($urandom % 16) == 0;
            sample();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
